axi_crossbar_write_mux: RTL

//  Write-path consumer of the crossbar round-robin arbiter's one-hot grant.
//  - Drives masked AWVALIDs to the arbiter; latches the granted master.
//  - Routes that master's AW and W channels to one slave port.
//  - Holds the lock until both the AW handshake and the WLAST handshake complete.
//  - Checks the W beat count against AWLEN.

---
 rtl/axi_crossbar_pkg.sv | 18 +
 rtl/axi_crossbar_onehot_mux.sv | 19 +
 rtl/axi_crossbar_write_mux.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/axi_crossbar_pkg.sv
// Shared types and width helpers for the AXI crossbar write path.
// Imported by the write mux and its one-hot select sub-module.
package axi_crossbar_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    function automatic int strb_w(input int dw);
        return dw / 8;
    endfunction

    function automatic int cnt_w(input int lw);
        return lw + 1;
    endfunction

endpackage

// File: rtl/axi_crossbar_onehot_mux.sv
// AND-OR select of one of N W-bit lanes by a one-hot vector.
// An all-zero select yields zero, which keeps idle outputs quiet.
module axi_crossbar_onehot_mux #(
    parameter int N = 3,
    parameter int W = 32
) (
    input  logic [N-1:0]   i_sel,
    input  logic [N*W-1:0] i_data,
    output logic [W-1:0]   o_data
);

    always_comb begin
        o_data = '0;
        for (int i = 0; i < N; i++) begin
            o_data = o_data | (i_data[i*W +: W] & {W{i_sel[i]}});
        end
    end

endmodule

// File: rtl/axi_crossbar_write_mux.sv
// Write-path owner of the crossbar slave port: locks one master from
// its AW grant until both AW and the WLAST beat have handshaken.
module axi_crossbar_write_mux
    import axi_crossbar_pkg::*;
#(
    parameter int AXI_REQUEST_NUM = 3,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int LEN_WIDTH       = 8
) (
    input  logic                                         ACLK,
    input  logic                                         ARESETN,
    output logic [AXI_REQUEST_NUM-1:0]                   requests_o,
    input  logic [AXI_REQUEST_NUM-1:0]                   grant_i,
    input  logic [AXI_REQUEST_NUM-1:0]                   s_awvalid,
    output logic [AXI_REQUEST_NUM-1:0]                   s_awready,
    input  logic [AXI_REQUEST_NUM*ADDR_WIDTH-1:0]        s_awaddr,
    input  logic [AXI_REQUEST_NUM*LEN_WIDTH-1:0]         s_awlen,
    input  logic [AXI_REQUEST_NUM-1:0]                   s_wvalid,
    output logic [AXI_REQUEST_NUM-1:0]                   s_wready,
    input  logic [AXI_REQUEST_NUM*DATA_WIDTH-1:0]        s_wdata,
    input  logic [AXI_REQUEST_NUM*(DATA_WIDTH/8)-1:0]    s_wstrb,
    input  logic [AXI_REQUEST_NUM-1:0]                   s_wlast,
    output logic                                         m_awvalid,
    input  logic                                         m_awready,
    output logic [ADDR_WIDTH-1:0]                        m_awaddr,
    output logic [LEN_WIDTH-1:0]                         m_awlen,
    output logic                                         m_wvalid,
    input  logic                                         m_wready,
    output logic [DATA_WIDTH-1:0]                        m_wdata,
    output logic [DATA_WIDTH/8-1:0]                      m_wstrb,
    output logic                                         m_wlast,
    output logic [AXI_REQUEST_NUM-1:0]                   sel_o,
    output logic                                         len_err_o
);

    localparam int N  = AXI_REQUEST_NUM;
    localparam int SW = strb_w(DATA_WIDTH);
    localparam int CW = cnt_w(LEN_WIDTH);

    state_t               r_state;
    logic [N-1:0]         r_sel;
    logic                 r_aw_done;
    logic                 r_w_done;
    logic [CW-1:0]        r_beat_cnt;
    logic [LEN_WIDTH-1:0] r_len;
    logic                 r_len_err;

    logic [N-1:0]         w_gv;
    logic [N-1:0]         w_pick;
    logic [LEN_WIDTH-1:0] w_pick_len;
    logic                 w_awvalid;
    logic                 w_wvalid;
    logic                 w_wlast;
    logic                 w_aw_hs;
    logic                 w_w_hs;
    logic                 w_last_hs;
    logic                 w_cnt_eq;
    logic                 w_len_bad;
    logic                 w_done;

    // Defensive: reduce the qualified grant to its lowest set bit.
    assign w_gv   = grant_i & s_awvalid;
    assign w_pick = w_gv & (~w_gv + N'(1));

    axi_crossbar_onehot_mux #(.N(N), .W(LEN_WIDTH)) u_pick_len (
        .i_sel(w_pick), .i_data(s_awlen), .o_data(w_pick_len)
    );
    axi_crossbar_onehot_mux #(.N(N), .W(ADDR_WIDTH)) u_awaddr (
        .i_sel(r_sel), .i_data(s_awaddr), .o_data(m_awaddr)
    );
    axi_crossbar_onehot_mux #(.N(N), .W(LEN_WIDTH)) u_awlen (
        .i_sel(r_sel), .i_data(s_awlen), .o_data(m_awlen)
    );
    axi_crossbar_onehot_mux #(.N(N), .W(DATA_WIDTH)) u_wdata (
        .i_sel(r_sel), .i_data(s_wdata), .o_data(m_wdata)
    );
    axi_crossbar_onehot_mux #(.N(N), .W(SW)) u_wstrb (
        .i_sel(r_sel), .i_data(s_wstrb), .o_data(m_wstrb)
    );
    axi_crossbar_onehot_mux #(.N(N), .W(1)) u_awvalid (
        .i_sel(r_sel), .i_data(s_awvalid), .o_data(w_awvalid)
    );
    axi_crossbar_onehot_mux #(.N(N), .W(1)) u_wvalid (
        .i_sel(r_sel), .i_data(s_wvalid), .o_data(w_wvalid)
    );
    axi_crossbar_onehot_mux #(.N(N), .W(1)) u_wlast (
        .i_sel(r_sel), .i_data(s_wlast), .o_data(w_wlast)
    );

    assign requests_o = s_awvalid & {N{r_state == IDLE}};
    assign m_awvalid  = w_awvalid & ~r_aw_done;
    assign m_wvalid   = w_wvalid & ~r_w_done;
    assign m_wlast    = w_wlast;
    assign s_awready  = r_sel & {N{m_awready & ~r_aw_done}};
    assign s_wready   = r_sel & {N{m_wready & ~r_w_done}};
    assign sel_o      = r_sel;
    assign len_err_o  = r_len_err;

    assign w_aw_hs   = m_awvalid & m_awready;
    assign w_w_hs    = m_wvalid & m_wready;
    assign w_last_hs = w_w_hs & w_wlast;
    assign w_cnt_eq  = (r_beat_cnt == {1'b0, r_len});
    // Error when WLAST and the final-beat position disagree.
    assign w_len_bad = w_w_hs & (w_wlast ^ w_cnt_eq);
    assign w_done    = (r_aw_done | w_aw_hs) & (r_w_done | w_last_hs);

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state    <= IDLE;
            r_sel      <= '0;
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
            r_beat_cnt <= '0;
            r_len      <= '0;
            r_len_err  <= 1'b0;
        end else begin
            r_len_err <= w_len_bad;
            unique case (r_state)
                IDLE: begin
                    if (|w_gv) begin
                        r_sel   <= w_pick;
                        r_len   <= w_pick_len;
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    if (w_done) begin
                        r_state    <= IDLE;
                        r_sel      <= '0;
                        r_aw_done  <= 1'b0;
                        r_w_done   <= 1'b0;
                        r_beat_cnt <= '0;
                    end else begin
                        if (w_aw_hs) r_aw_done <= 1'b1;
                        if (w_last_hs) r_w_done <= 1'b1;
                        if (w_w_hs && r_beat_cnt != '1) begin
                            r_beat_cnt <= r_beat_cnt + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule
